adc_seq_ctrl: RTL and testbench
===============================

ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 Parameter NUM_CH, default 5: number of ADC channels, numbered 1..NUM_CH.
REQ-002 Parameter DATA_W, default 12: ADC result width.
REQ-003 Parameter SETTLE_CYC, default 10: mux settle cycles before each conversion command.
REQ-004 Parameter TIMEOUT_CYC, default 64: maximum cycles to wait for a response after command acceptance.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 Port: clk_i  in  1  system clock; all state changes on its rising edge.
REQ-007 Port: reset_i  in  1  synchronous active-high reset.
REQ-008 Port: enable_i  in  1  run continuous scan when high.
REQ-009 Port: ch_mask_i  in  NUM_CH  bit k enables channel k+1.
REQ-010 Port: cmd_valid_o  out  1  conversion request to the ADC.
REQ-011 Port: cmd_channel_o  out  5  channel to select/convert (1..NUM_CH).
REQ-012 Port: cmd_ready_i  in  1  ADC accepts the request.
REQ-013 Port: rsp_valid_i  in  1  ADC result valid, one-cycle pulse.
REQ-014 Port: rsp_channel_i  in  5  channel tag of the result.
REQ-015 Port: rsp_data_i  in  DATA_W  conversion result.
REQ-016 Port: sample_o  out  NUM_CH*DATA_W  latest result per channel; slot k at bits [k*DATA_W +: DATA_W] for channel k+1.
REQ-017 Port: sample_valid_o  out  NUM_CH  bit k set when slot k holds a good result.
REQ-018 Port: update_o  out  1  one-cycle pulse when a slot is written.
REQ-019 Port: update_ch_o  out  5  channel written, valid with update_o.
REQ-020 Port: timeout_o  out  1  one-cycle pulse when a conversion times out.

Function
REQ-021 The FSM SHALL have states IDLE, SETTLE, CMD, WAIT.
REQ-022 In IDLE with enable_i=1 and ch_mask_i nonzero, the block SHALL select the first enabled channel at or after the current channel (wrapping NUM_CH->1) and enter SETTLE; otherwise it stays in IDLE.
REQ-023 In SETTLE, cmd_channel_o SHALL show the selected channel; after exactly SETTLE_CYC cycles in SETTLE, the FSM enters CMD.
REQ-024 In CMD, cmd_valid_o SHALL be 1 with cmd_channel_o stable until the cycle cmd_valid_o&cmd_ready_i=1; it then enters WAIT with the timeout counter cleared. cmd_valid_o is never withdrawn before acceptance, including when enable_i falls.
REQ-025 In WAIT, rsp_valid_i=1 with rsp_channel_i equal to the selected channel SHALL write rsp_data_i to that slot, set its sample_valid_o bit, and pulse update_o/update_ch_o in the next cycle.
REQ-026 A response with a mismatched tag, or any rsp_valid_i outside WAIT, SHALL be ignored.
REQ-027 When the WAIT counter reaches TIMEOUT_CYC with no matching response, the block SHALL pulse timeout_o, clear that channel's sample_valid_o bit, and leave sample_o unchanged.
REQ-028 A matching response arriving in the same cycle as the timeout SHALL be accepted as in REQ-025, with no timeout_o pulse.
REQ-029 On leaving WAIT, the next channel SHALL be the next set bit of ch_mask_i after the current channel (wrapping); with one bit set, the same channel repeats.
REQ-030 On leaving WAIT, the FSM SHALL go to IDLE if enable_i=0 or ch_mask_i=0, else to SETTLE.
REQ-031 ch_mask_i changes SHALL take effect only at channel selection; an in-flight conversion always completes or times out.
REQ-032 sample_o slots SHALL hold their value until overwritten or reset.

Reset
REQ-033 While reset_i=1 at a clock edge, the block SHALL enter IDLE with current channel 1, cmd_channel_o=1, cmd_valid_o=0, sample_o=0, sample_valid_o=0, update_o=0, update_ch_o=0, timeout_o=0, all counters 0.
REQ-034 Reset asserted in any state, including CMD before acceptance, SHALL drop cmd_valid_o on the following cycle with no update_o or timeout_o pulse.

Verification
REQ-035 Reset release, enable_i=1, mask=5'b11111, cmd_ready_i=1, responses 3 cycles after acceptance -> cmd_valid_o first high 11 cycles after enable_i is sampled; cmd_channel_o sequence 1,2,3,4,5,1; update_ch_o matches.
REQ-036 mask=5'b10100, data=channel*100 -> only channels 3 and 5 are converted, alternating; slot 2=300 and slot 4=500; sample_valid_o=5'b10100.
REQ-037 cmd_ready_i held 0 for 20 cycles in CMD, enable_i dropped meanwhile -> cmd_valid_o and cmd_channel_o stay stable; after acceptance and response, FSM returns to IDLE.
REQ-038 No response for channel 2 -> timeout_o pulses exactly 64 cycles after acceptance; sample_valid_o[1] clears; scan continues with channel 3.
REQ-039 Response with tag 4 while waiting on channel 1 -> ignored; matching response in the timeout cycle -> accepted with no timeout_o.
REQ-040 reset_i pulsed mid-WAIT -> all outputs return to their reset values; the next scan starts at channel 1.

Source files
------------

// File: rtl/adc_seq_ctrl.sv
// Round-robin ADC scan sequencer: settles the mux, issues one conversion per enabled
// channel and keeps the latest result (with a validity flag) for every channel.
module adc_seq_ctrl #(
    parameter int unsigned NUM_CH      = 5,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned SETTLE_CYC  = 10,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [NUM_CH-1:0]        ch_mask_i,
    output logic                     cmd_valid_o,
    output logic [4:0]               cmd_channel_o,
    input  logic                     cmd_ready_i,
    input  logic                     rsp_valid_i,
    input  logic [4:0]               rsp_channel_i,
    input  logic [DATA_W-1:0]        rsp_data_i,
    output logic [NUM_CH*DATA_W-1:0] sample_o,
    output logic [NUM_CH-1:0]        sample_valid_o,
    output logic                     update_o,
    output logic [4:0]               update_ch_o,
    output logic                     timeout_o
);
    localparam int unsigned MAX_CYC = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCmd, StWait} state_e;

    state_e                   state_q, state_d;
    logic [4:0]               ch_q, ch_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_CH*DATA_W-1:0] sample_q, sample_d;
    logic [NUM_CH-1:0]        valid_q, valid_d;
    logic                     update_q, update_d;
    logic [4:0]               update_ch_q, update_ch_d;
    logic                     timeout_q, timeout_d;

    logic [2*NUM_CH-1:0]      mask_dbl;
    logic [NUM_CH-1:0]        rot_at, rot_after;
    logic [4:0]               ch_at, ch_after;
    logic                     rsp_match;
    logic                     leave;

    // Zero-based index that may overrun by less than NUM_CH -> one-based channel number.
    function automatic logic [4:0] wrap_ch(input logic [5:0] idx);
        logic [5:0] w;
        w = (idx >= 6'(NUM_CH)) ? idx - 6'(NUM_CH) : idx;
        return 5'(w + 6'd1);
    endfunction

    // Rotate the mask so bit 0 is the current channel (at) or the one after it (after),
    // then the lowest set bit is the wanted channel.
    always_comb begin
        mask_dbl  = {ch_mask_i, ch_mask_i};
        rot_at    = NUM_CH'(mask_dbl >> (ch_q - 5'd1));
        rot_after = NUM_CH'(mask_dbl >> ch_q);
        ch_at     = ch_q;
        ch_after  = ch_q;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (rot_at[i])    ch_at    = wrap_ch({1'b0, ch_q} - 6'd1 + 6'(i));
            if (rot_after[i]) ch_after = wrap_ch({1'b0, ch_q} + 6'(i));
        end
    end

    assign rsp_match = rsp_valid_i && (rsp_channel_i == ch_q);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        valid_d     = valid_q;
        update_d    = 1'b0;
        update_ch_d = '0;
        timeout_d   = 1'b0;
        leave       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_i && (|ch_mask_i)) begin
                    ch_d    = ch_at;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StCmd;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCmd: begin
                if (cmd_ready_i) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A matching response wins over a timeout landing in the same cycle.
                if (rsp_match) begin
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        if (5'(k + 1) == ch_q) begin
                            sample_d[k*DATA_W +: DATA_W] = rsp_data_i;
                            valid_d[k]                   = 1'b1;
                        end
                    end
                    update_d    = 1'b1;
                    update_ch_d = ch_q;
                    leave       = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        if (5'(k + 1) == ch_q) valid_d[k] = 1'b0;
                    end
                    timeout_d = 1'b1;
                    leave     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (leave) begin
                    cnt_d = '0;
                    if (|ch_mask_i) ch_d = ch_after;
                    state_d = (enable_i && (|ch_mask_i)) ? StSettle : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            ch_q        <= 5'd1;
            cnt_q       <= '0;
            sample_q    <= '0;
            valid_q     <= '0;
            update_q    <= 1'b0;
            update_ch_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            update_ch_q <= update_ch_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_valid_o    = (state_q == StCmd);
    assign cmd_channel_o  = ch_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign update_o       = update_q;
    assign update_ch_o    = update_ch_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: a procedural ADC model drives commands/responses while a
// transaction-level model predicts scan order, slot contents and pulse timing.
module tb_adc_seq_ctrl;
    localparam int NUM_CH      = 5;
    localparam int DATA_W      = 12;
    localparam int SETTLE_CYC  = 10;
    localparam int TIMEOUT_CYC = 64;

    logic                     clk = 1'b0;
    logic                     reset, enable, cmd_ready, rsp_valid;
    logic [NUM_CH-1:0]        ch_mask;
    logic                     cmd_valid;
    logic [4:0]               cmd_channel, rsp_channel, update_ch;
    logic [DATA_W-1:0]        rsp_data;
    logic [NUM_CH*DATA_W-1:0] sample;
    logic [NUM_CH-1:0]        sample_valid;
    logic                     update, timeout;

    int nvec = 0;
    int nerr = 0;

    logic [DATA_W-1:0] m_sample [NUM_CH];
    logic [NUM_CH-1:0] m_valid;
    int                m_ch;
    bit                m_idle;

    typedef struct {
        logic [NUM_CH-1:0] mask;
        int                c0, c1, c2;
        logic [NUM_CH-1:0] vld;
    } vec_t;
    vec_t tbl [6];

    adc_seq_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .ch_mask_i(ch_mask),
        .cmd_valid_o(cmd_valid), .cmd_channel_o(cmd_channel), .cmd_ready_i(cmd_ready),
        .rsp_valid_i(rsp_valid), .rsp_channel_i(rsp_channel), .rsp_data_i(rsp_data),
        .sample_o(sample), .sample_valid_o(sample_valid), .update_o(update),
        .update_ch_o(update_ch), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scan order from the rules: first enabled channel at/after ch, wrapping NUM_CH -> 1.
    function automatic int first_at(input int ch, input logic [NUM_CH-1:0] m);
        for (int i = 0; i < NUM_CH; i++) begin
            int c;
            c = (ch - 1 + i) % NUM_CH + 1;
            if (m[c-1]) return c;
        end
        return ch;
    endfunction

    function automatic int next_after(input int ch, input logic [NUM_CH-1:0] m);
        return first_at(ch % NUM_CH + 1, m);
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] m_pack();
        logic [NUM_CH*DATA_W-1:0] p;
        for (int k = 0; k < NUM_CH; k++) p[k*DATA_W +: DATA_W] = m_sample[k];
        return p;
    endfunction

    function automatic logic [NUM_CH-1:0] rnd_mask();
        logic [NUM_CH-1:0] m;
        do m = NUM_CH'($urandom); while (m == '0);
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_sample[k] = '0;
        m_valid = '0;
        m_ch    = 1;
        m_idle  = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_channel"}, cmd_channel, 1);
        check({tag, "_sample"}, sample, 0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_update"}, update, 0);
        check({tag, "_update_ch"}, update_ch, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; cmd_ready = 0; rsp_valid = 0; rsp_channel = '0; rsp_data = '0;
        tick();
        tick();
        reset = 0;
        model_reset();
    endtask

    // Wait for a command, hold ready low for ready_dly cycles, then accept it.
    task automatic accept(input int ready_dly, input int drop_at, output int waited);
        int exp_ch;
        waited = 0;
        while (!cmd_valid && waited < 400) begin
            tick();
            waited++;
        end
        exp_ch = m_idle ? first_at(m_ch, ch_mask) : m_ch;
        m_ch   = exp_ch;
        m_idle = 1'b0;
        check("cmd_valid", cmd_valid, 1);
        check("cmd_channel", cmd_channel, exp_ch);
        for (int i = 0; i < ready_dly; i++) begin
            if (i == drop_at) enable = 0;
            tick();
            check("cmd_hold", {cmd_valid, cmd_channel}, {1'b1, 5'(exp_ch)});
        end
        cmd_ready = 1;
        tick();
        cmd_ready = 0;
        check("cmd_after_accept", cmd_valid, 0);
    endtask

    // Matching response sampled lat cycles after acceptance (lat > TIMEOUT_CYC: none);
    // optional wrong-tag response at wrong_at.
    task automatic respond(input int lat, input int wrong_at, input logic [DATA_W-1:0] data);
        bit done;
        bit exp_upd, exp_to;
        done = 1'b0;
        for (int k = 1; k <= TIMEOUT_CYC && !done; k++) begin
            rsp_valid   = (k == lat) || (k == wrong_at);
            rsp_channel = (k == lat) ? 5'(m_ch) : 5'((m_ch + 2) % NUM_CH + 1);
            rsp_data    = (k == lat) ? data : ~data;
            tick();
            rsp_valid = 0;
            exp_upd = (k == lat);
            exp_to  = (k == TIMEOUT_CYC) && (lat > TIMEOUT_CYC);
            check("update", update, exp_upd);
            check("timeout", timeout, exp_to);
            done = exp_upd || exp_to;
        end
        if (lat <= TIMEOUT_CYC) begin
            m_sample[m_ch-1] = data;
            m_valid[m_ch-1]  = 1'b1;
            check("update_ch", update_ch, m_ch);
        end else begin
            m_valid[m_ch-1] = 1'b0;
        end
        check("sample", sample, m_pack());
        check("sample_valid", sample_valid, m_valid);
        if (ch_mask != '0) m_ch = next_after(m_ch, ch_mask);
        m_idle = !(enable && ch_mask != '0);
        tick();
        check("pulse_end", {update, timeout}, 2'b00);
    endtask

    initial begin
        int w;
        int seq035 [6];
        tbl[0] = '{5'b11111, 1, 2, 3, 5'b00111};
        tbl[1] = '{5'b10100, 3, 5, 3, 5'b10100};
        tbl[2] = '{5'b00001, 1, 1, 1, 5'b00001};
        tbl[3] = '{5'b10000, 5, 5, 5, 5'b10000};
        tbl[4] = '{5'b01010, 2, 4, 2, 5'b01010};
        tbl[5] = '{5'b00110, 2, 3, 2, 5'b00110};
        seq035 = '{1, 2, 3, 4, 5, 1};

        // Reset values and idling while disabled
        ch_mask = 5'b11111;
        do_reset();
        check_reset_vals("reset");
        repeat (5) tick();
        check("idle_disabled", cmd_valid, 0);

        // First command latency and full scan order
        enable = 1;
        accept(0, -1, w);
        check("first_cmd_latency", w, SETTLE_CYC + 1);
        check("scan_ch_0", cmd_channel, seq035[0]);
        respond(3, 0, DATA_W'(m_ch * 100));
        for (int i = 1; i < 6; i++) begin
            accept(0, -1, w);
            check("scan_ch", cmd_channel, seq035[i]);
            respond(3, 0, DATA_W'(m_ch * 100));
        end

        // Table: channel selection per mask from reset
        for (int t = 0; t < 6; t++) begin
            do_reset();
            ch_mask = tbl[t].mask;
            enable  = 1;
            for (int j = 0; j < 3; j++) begin
                accept(int'($urandom_range(0, 3)), -1, w);
                check("tbl_ch", cmd_channel, (j == 0) ? tbl[t].c0 : (j == 1) ? tbl[t].c1 : tbl[t].c2);
                respond(int'($urandom_range(1, 8)), 0, DATA_W'(m_ch * 100));
            end
            check("tbl_valid", sample_valid, tbl[t].vld);
            if (tbl[t].mask == 5'b10100) begin
                check("slot_ch3", sample[2*DATA_W +: DATA_W], 300);
                check("slot_ch5", sample[4*DATA_W +: DATA_W], 500);
            end
        end

        // Backpressure in CMD with enable dropped meanwhile -> finish, then idle
        do_reset();
        ch_mask = 5'b11111;
        enable  = 1;
        accept(20, 5, w);
        respond(3, 0, 12'h123);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("idle_after_drop", cmd_valid, 0);
        end

        // Timeout on channel 2 after a full scan, then channels 3.., then late match
        do_reset();
        ch_mask = 5'b11111;
        enable  = 1;
        for (int i = 0; i < 6; i++) begin
            accept(0, -1, w);
            respond(2, 0, DATA_W'(m_ch * 7 + 1));
        end
        accept(0, -1, w);
        check("to_ch2", cmd_channel, 2);
        respond(TIMEOUT_CYC + 1, 0, '0);
        check("to_valid_bit", sample_valid[1], 0);
        accept(0, -1, w);
        check("after_to_ch3", cmd_channel, 3);
        respond(4, 0, 12'h333);
        for (int i = 0; i < 2; i++) begin
            accept(0, -1, w);
            respond(4, 0, DATA_W'($urandom));
        end
        accept(0, -1, w);
        check("late_ch1", cmd_channel, 1);
        respond(TIMEOUT_CYC, 10, 12'hA5C);

        // Response while not waiting is ignored
        rsp_valid = 1; rsp_channel = 5'(m_ch); rsp_data = 12'hFFF;
        tick();
        rsp_valid = 0;
        tick();
        check("stray_update", update, 0);
        check("stray_sample", sample, m_pack());
        check("stray_valid", sample_valid, m_valid);

        // Reset in CMD before acceptance, then reset mid-WAIT
        do_reset();
        ch_mask = 5'b11111;
        enable  = 1;
        accept(0, -1, w);
        respond(3, 0, 12'h456);
        w = 0;
        while (!cmd_valid && w < 100) begin
            tick();
            w++;
        end
        check("pre_reset_cmd", cmd_valid, 1);
        reset = 1;
        tick();
        check_reset_vals("reset_cmd");
        reset = 0;
        model_reset();
        accept(0, -1, w);
        check("restart_ch1", cmd_channel, 1);
        respond(3, 0, 12'h789);
        accept(0, -1, w);
        repeat (5) tick();
        reset = 1;
        tick();
        check_reset_vals("reset_wait");
        reset = 0;
        model_reset();
        accept(0, -1, w);
        check("restart2_ch1", cmd_channel, 1);
        respond(2, 0, 12'h111);

        // Randomized scan against the model
        do_reset();
        ch_mask = 5'b11111;
        for (int it = 0; it < 60; it++) begin
            int lat, wa;
            enable = 1;
            if ($urandom_range(0, 3) == 0) ch_mask = rnd_mask();
            accept(int'($urandom_range(0, 4)), -1, w);
            if ($urandom_range(0, 3) == 0) ch_mask = rnd_mask();
            if ($urandom_range(0, 4) == 0) enable = 0;
            lat = ($urandom_range(0, 3) == 0) ? TIMEOUT_CYC + 1
                                              : int'($urandom_range(1, TIMEOUT_CYC));
            wa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TIMEOUT_CYC - 1)) : 0;
            if (wa == lat) wa = 0;
            respond(lat, wa, DATA_W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
